conv_layer_sequencer: RTL and testbench

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

---
 rtl/conv_pkg.sv | 42 ++++
 rtl/conv_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_conv_layer_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and limits for the convolution layer sequencer: the layer
// configuration record, the sequencer state encoding and a legality check.
package conv_pkg;

    localparam int KERNEL_W_MAX         = 8;
    localparam int KERNEL_H_MAX         = 8;
    localparam int KERNEL_FIELD_W       = 4;
    localparam int CIN_COUNTER_WIDTH    = 8;
    localparam int COLS_COUNTER_WIDTH   = 10;
    localparam int BLOCKS_COUNTER_WIDTH = 8;

    // All "_1" fields hold (count - 1) so that the full range of each field is usable.
    typedef struct packed {
        logic [KERNEL_FIELD_W-1:0]       kernel_w_1;
        logic [KERNEL_FIELD_W-1:0]       kernel_h_1;
        logic                            is_max;
        logic                            is_relu;
        logic [COLS_COUNTER_WIDTH-1:0]   cols_1;
        logic [CIN_COUNTER_WIDTH-1:0]    cin_1;
        logic [BLOCKS_COUNTER_WIDTH-1:0] blocks_1;
    } conv_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // A kernel wider/taller than the engine supports, or with an even height
    // (odd kernel_h_1), cannot be run and is rejected at the handshake.
    function automatic logic cfg_is_illegal(input conv_cfg_t c);
        logic w_too_wide;
        logic w_too_tall;
        logic w_even_height;
        w_too_wide    = (c.kernel_w_1 > KERNEL_FIELD_W'(KERNEL_W_MAX - 1));
        w_too_tall    = (c.kernel_h_1 > KERNEL_FIELD_W'(KERNEL_H_MAX - 1));
        w_even_height = c.kernel_h_1[0];
        return w_too_wide | w_too_tall | w_even_height;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer.sv
// Layer sequencer for the convolution engine: accepts one layer configuration
// at a time, fires the engine start pulse, counts closed output blocks and
// signals completion, with an idle watchdog that aborts a stalled layer.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int TIMEOUT_W = 16
)
(
    input  logic      aclk,
    input  logic      aresetn,
    input  logic      cfg_valid,
    output logic      cfg_ready,
    input  conv_cfg_t cfg_data,
    output logic      start,
    output conv_cfg_t layer_cfg,
    input  logic      eng_m_valid,
    input  logic      eng_m_last,
    output logic      busy,
    output logic      done,
    output logic      cfg_err,
    output logic      timeout
);

    conv_state_t                     r_state;
    logic [BLOCKS_COUNTER_WIDTH-1:0] r_blk_cnt;
    logic [TIMEOUT_W-1:0]            r_wdog;
    conv_cfg_t                       r_layer_cfg;
    logic                            r_start;
    logic                            r_done;
    logic                            r_cfg_err;
    logic                            r_timeout;
    logic                            r_busy;
    logic                            r_cfg_ready;

    logic w_cfg_accept;
    logic w_cfg_illegal;
    logic w_wdog_full;

    assign w_cfg_accept  = cfg_valid & r_cfg_ready;
    assign w_cfg_illegal = cfg_is_illegal(cfg_data);
    assign w_wdog_full   = &r_wdog;

    // Sequencer FSM with block counter and watchdog; every output is registered.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_blk_cnt   <= '0;
            r_wdog      <= '0;
            r_layer_cfg <= '0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            // Pulses are single-cycle unless a branch below re-asserts them.
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    if (w_cfg_accept) begin
                        if (w_cfg_illegal) begin
                            // Rejected: stay ready, keep the previous layer_cfg.
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_layer_cfg <= cfg_data;
                            r_start     <= 1'b1;
                            r_busy      <= 1'b1;
                            r_cfg_ready <= 1'b0;
                            r_state     <= ST_START;
                        end
                    end
                end

                ST_START: begin
                    r_blk_cnt <= r_layer_cfg.blocks_1;
                    r_wdog    <= '0;
                    r_state   <= ST_RUN;
                end

                ST_RUN: begin
                    if (eng_m_valid) begin
                        r_wdog <= '0;
                        if (eng_m_last) begin
                            if (r_blk_cnt != '0) begin
                                r_blk_cnt <= r_blk_cnt - BLOCKS_COUNTER_WIDTH'(1);
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end
                    end else if (w_wdog_full) begin
                        // Engine stalled too long: abort without a done pulse.
                        r_timeout   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + TIMEOUT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign start     = r_start;
    assign layer_cfg = r_layer_cfg;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: expected pulses (start, done,
// cfg_err, timeout) with their cycle numbers are queued as stimulus is driven
// and matched against the DUT pulses as they appear.
module tb_conv_layer_sequencer;
    import conv_pkg::*;

    localparam int TW = 4;

    localparam int EV_START   = 1;
    localparam int EV_DONE    = 2;
    localparam int EV_ERR     = 3;
    localparam int EV_TIMEOUT = 4;

    logic      aclk        = 1'b0;
    logic      aresetn     = 1'b0;
    logic      cfg_valid   = 1'b0;
    conv_cfg_t cfg_data    = '0;
    logic      eng_m_valid = 1'b0;
    logic      eng_m_last  = 1'b0;
    logic      cfg_ready;
    logic      start;
    conv_cfg_t layer_cfg;
    logic      busy;
    logic      done;
    logic      cfg_err;
    logic      timeout;

    conv_layer_sequencer #(.TIMEOUT_W(TW)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .start       (start),
        .layer_cfg   (layer_cfg),
        .eng_m_valid (eng_m_valid),
        .eng_m_last  (eng_m_last),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .timeout     (timeout)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    // Cycle counter used to timestamp expected and observed pulses.
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int        kind;
        int        cyc;
        conv_cfg_t cfg;
    } exp_ev_t;

    exp_ev_t exp_q[$];

    // Reference model of the block countdown for the active layer.
    bit m_active  = 1'b0;
    int m_left    = 0;
    int m_run_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop and compare one expected event for every pulse the DUT raises.
    always @(negedge aclk) begin
        logic [3:0] pulses;
        exp_ev_t    e;
        pulses = {timeout, cfg_err, done, start};
        for (int k = 0; k < 4; k++) begin
            if (pulses[k]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'(k + 1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    $display("event kind=%0d at cycle %0d (expected kind=%0d cycle %0d)", k + 1, cyc, e.kind, e.cyc);
                    check("event_kind", 64'(k + 1), 64'(e.kind));
                    check("event_cycle", 64'(cyc), 64'(e.cyc));
                    if (k == 0) check("start_layer_cfg", 64'(layer_cfg), 64'(e.cfg));
                    if (k == 1) check("done_busy", 64'(busy), 64'(1));
                end
            end
        end
    end

    function automatic conv_cfg_t mk_cfg(input int w1, input int h1, input int blk1, input int cols1, input int cin1);
        conv_cfg_t c;
        c            = '0;
        c.kernel_w_1 = KERNEL_FIELD_W'(w1);
        c.kernel_h_1 = KERNEL_FIELD_W'(h1);
        c.is_relu    = 1'b1;
        c.is_max     = cols1[0];
        c.cols_1     = COLS_COUNTER_WIDTH'(cols1);
        c.cin_1      = CIN_COUNTER_WIDTH'(cin1);
        c.blocks_1   = BLOCKS_COUNTER_WIDTH'(blk1);
        return c;
    endfunction

    function automatic bit is_legal(input conv_cfg_t c);
        return (int'(c.kernel_w_1) <= KERNEL_W_MAX - 1) &&
               (int'(c.kernel_h_1) <= KERNEL_H_MAX - 1) &&
               (c.kernel_h_1[0] == 1'b0);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Offer one configuration (waiting for cfg_ready) and queue its outcome.
    task automatic send_cfg(input conv_cfg_t c);
        int w;
        w = 0;
        while (!cfg_ready && w < 100) begin
            tick();
            w++;
        end
        if (!cfg_ready) begin
            check("cfg_ready_wait", 64'(cfg_ready), 64'(1));
            return;
        end
        cfg_valid = 1'b1;
        cfg_data  = c;
        if (is_legal(c)) begin
            exp_q.push_back('{kind: EV_START, cyc: cyc + 1, cfg: c});
            m_active  = 1'b1;
            m_left    = int'(c.blocks_1);
            m_run_cyc = cyc + 2;
        end else begin
            exp_q.push_back('{kind: EV_ERR, cyc: cyc + 1, cfg: '0});
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    // One engine beat; the model decides whether it closes the layer.
    task automatic beat(input logic v, input logic l);
        eng_m_valid = v;
        eng_m_last  = l;
        if (v && l && m_active && cyc >= m_run_cyc) begin
            if (m_left == 0) begin
                exp_q.push_back('{kind: EV_DONE, cyc: cyc + 1, cfg: '0});
                m_active = 1'b0;
            end else begin
                m_left--;
            end
        end
        tick();
        eng_m_valid = 1'b0;
        eng_m_last  = 1'b0;
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL global_time_limit: got stall expected completion");
        $fatal(1);
    end

    // Main stimulus sequence.
    initial begin
        conv_cfg_t cfg_a, cfg_b, cfg_c, cfg_d, cfg_e, cfg_f, bad;
        int f, s;

        // Reset state and release.
        aresetn = 1'b0;
        repeat (3) tick();
        check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_start", 64'(start), 64'(0));
        check("rst_layer_cfg", 64'(layer_cfg), 64'(0));
        aresetn = 1'b1;
        tick();
        check("release_cfg_ready", 64'(cfg_ready), 64'(1));
        check("release_busy", 64'(busy), 64'(0));

        // Legal layer with four output blocks; a last-beat in START is ignored.
        cfg_a = mk_cfg(2, 2, 3, 5, 7);
        send_cfg(cfg_a);
        check("t1_busy_start", 64'(busy), 64'(1));
        check("t1_ready_start", 64'(cfg_ready), 64'(0));
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t1_busy_run", 64'(busy), 64'(1));
            beat(1'b1, 1'b1);
        end
        check("t1_busy_done", 64'(busy), 64'(1));
        check("t1_ready_done", 64'(cfg_ready), 64'(0));
        tick();
        check("t1_ready_after", 64'(cfg_ready), 64'(1));
        check("t1_busy_after", 64'(busy), 64'(0));

        // Illegal configurations: odd kernel_h_1, then kernel_w_1 at the limit.
        bad = mk_cfg(2, 1, 0, 1, 1);
        send_cfg(bad);
        check("t2a_layer_cfg", 64'(layer_cfg), 64'(cfg_a));
        check("t2a_ready", 64'(cfg_ready), 64'(1));
        check("t2a_busy", 64'(busy), 64'(0));
        tick();
        bad = mk_cfg(KERNEL_W_MAX, 0, 0, 1, 1);
        send_cfg(bad);
        check("t2b_layer_cfg", 64'(layer_cfg), 64'(cfg_a));
        check("t2b_ready", 64'(cfg_ready), 64'(1));
        // Last-beats while idle must have no effect.
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        check("t2_idle_busy", 64'(busy), 64'(0));

        // Back-to-back: second configuration held valid throughout the first layer.
        cfg_b = mk_cfg(0, 0, 1, 3, 2);
        cfg_c = mk_cfg(7, 6, 2, 9, 4);
        send_cfg(cfg_b);
        cfg_valid = 1'b1;
        cfg_data  = cfg_c;
        tick();
        check("t3_ready_run", 64'(cfg_ready), 64'(0));
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        check("t3_layer_cfg_stable", 64'(layer_cfg), 64'(cfg_b));
        f = cyc;
        beat(1'b1, 1'b1);
        exp_q.push_back('{kind: EV_START, cyc: f + 3, cfg: cfg_c});
        check("t3_ready_at_done", 64'(cfg_ready), 64'(0));
        tick();
        check("t3_ready_accept", 64'(cfg_ready), 64'(1));
        tick();
        cfg_valid = 1'b0;
        m_active  = 1'b1;
        m_left    = 2;
        m_run_cyc = f + 4;
        // Second layer: last without valid never counts a block.
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b1);
        tick();
        tick();

        // Single-block layer finishes on its first valid last-beat.
        cfg_d = mk_cfg(1, 4, 0, 2, 3);
        send_cfg(cfg_d);
        tick();
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b1);
        tick();
        tick();

        // Watchdog: no engine activity after start.
        cfg_e = mk_cfg(3, 2, 2, 4, 5);
        send_cfg(cfg_e);
        s = cyc;
        m_active = 1'b0;
        exp_q.push_back('{kind: EV_TIMEOUT, cyc: s + (1 << TW) + 1, cfg: '0});
        for (int i = 0; i < 40 && busy; i++) tick();
        check("t5_busy_cleared", 64'(busy), 64'(0));
        check("t5_ready", 64'(cfg_ready), 64'(1));
        check("t5_layer_cfg_held", 64'(layer_cfg), 64'(cfg_e));
        beat(1'b1, 1'b1);
        tick();

        // Reset in the middle of a layer.
        cfg_f = mk_cfg(4, 6, 5, 8, 8);
        send_cfg(cfg_f);
        tick();
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        m_active = 1'b0;
        aresetn  = 1'b0;
        tick();
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_ready", 64'(cfg_ready), 64'(0));
        check("t6_rst_pulses", 64'({start, done, cfg_err, timeout}), 64'(0));
        check("t6_rst_layer_cfg", 64'(layer_cfg), 64'(0));
        aresetn = 1'b1;
        tick();
        check("t6_release_ready", 64'(cfg_ready), 64'(1));
        check("t6_release_busy", 64'(busy), 64'(0));
        repeat (4) tick();

        check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
